// File: rtl/evaluador_colisiones_if.sv
// Obstacle-stream / game-state bundle between the obstacle generator + top
// FSM (master) and the collision evaluator (slave).
//   clk_obstaculos : obstacle tick level (sampled as data by the slave)
//   presente       : top FSM state code
//   mundo          : current world, 3 = all worlds cleared
//   tipo_obs       : type of the obstacle just written into cell [20:14]
//   display_obs    : 3-cell lane, [6:0] is the hero cell
//   boton_salto    : raw jump button
//   boton_agacharse: raw duck button
//   W_or_L         : 00 playing, 10 win, 01 lose
//   bono_tomado    : bonus collected
//   display_heroe  : hero glyph
//   vidas          : remaining lives (0 when the lives feature is off)
interface evaluador_colisiones_if;
  logic        clk_obstaculos;
  logic [2:0]  presente;
  logic [1:0]  mundo;
  logic [4:0]  tipo_obs;
  logic [20:0] display_obs;
  logic        boton_salto;
  logic        boton_agacharse;
  logic [1:0]  W_or_L;
  logic        bono_tomado;
  logic [6:0]  display_heroe;
  logic [1:0]  vidas;

  modport master (
    output clk_obstaculos, presente, mundo, tipo_obs, display_obs,
           boton_salto, boton_agacharse,
    input  W_or_L, bono_tomado, display_heroe, vidas
  );

  modport slave (
    input  clk_obstaculos, presente, mundo, tipo_obs, display_obs,
           boton_salto, boton_agacharse,
    output W_or_L, bono_tomado, display_heroe, vidas
  );
endinterface

// File: rtl/evaluador_colisiones.sv
// Collision evaluator: consumer end of the obstacle stream. Tracks the hero
// (run / jump / duck) against the hero cell of the obstacle lane and reports
// win/lose and bonus pickup back to the generator and top FSM.
// Ports:
//   clk : system clock (everything runs on it; the obstacle tick is data)
//   rst : asynchronous active-high reset
//   bus : evaluador_colisiones_if.slave (see interface header for fields)
// Optional build macro VIDAS_EN: 3-life counter with 2-evaluation
// invulnerability after each hit; without it the first collision loses and
// vidas is tied to 0.
module evaluador_colisiones #(
  parameter logic [2:0] GAME       = 3'd3,
  parameter logic [2:0] WL         = 3'd4,
  parameter int         JUMP_TICKS = 2,
  parameter logic [4:0] TIPO_BONO  = 5'd16,
  parameter logic [6:0] SEG_RUN    = 7'b0001000,
  parameter logic [6:0] SEG_JUMP   = 7'b0000001,
  parameter logic [6:0] SEG_DUCK   = 7'b1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  evaluador_colisiones_if.slave       bus
);

  localparam logic [1:0] JT = JUMP_TICKS[1:0];

  typedef enum logic [1:0] {S_RUN, S_JUMP, S_DUCK} estado_t;

  estado_t          r_est, w_est_nxt;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic [2:0]       r_tk_s;   // sync0, sync1, sync1 delayed
  logic [2:0]       r_sj_s;
  logic [1:0]       r_sd_s;
  logic             r_tk_d;   // marks cycle E
  logic [2:0][4:0]  r_tipo;   // type pipe; [2] lines up with hero cell
  logic [1:0]       r_wl;
  logic             r_bono;
  logic [6:0]       r_seg;

  logic w_tk, w_jreq, w_duck, w_salida, w_jugando;
  logic w_ocup, w_eval, w_bono_hit, w_choque, w_perder;
  logic w_unused_bits;

  assign w_tk      = r_tk_s[1] & ~r_tk_s[2];
  assign w_jreq    = r_sj_s[1] & ~r_sj_s[2];
  assign w_duck    = r_sd_s[1];
  assign w_salida  = (bus.presente != GAME) && (bus.presente != WL);
  assign w_jugando = (r_wl == 2'b00);

  // Only the hero cell matters here; the upper cells are the generator's.
  assign w_unused_bits = ^bus.display_obs[20:7];

  assign w_ocup     = |bus.display_obs[6:0];
  assign w_eval     = r_tk_d && (bus.presente == GAME) && w_jugando;
  assign w_bono_hit = w_eval && w_ocup && (r_tipo[2] == TIPO_BONO);
  // Odd type = ground obstacle (must jump); even non-bonus = aerial (must duck).
  assign w_choque   = w_eval && w_ocup &&
                      (( r_tipo[2][0] && (r_est != S_JUMP)) ||
                       (!r_tipo[2][0] && (r_tipo[2] != TIPO_BONO) && (r_est != S_DUCK)));

`ifdef VIDAS_EN
  logic [1:0] r_vidas;
  logic [1:0] r_inv;
  logic       w_golpe;

  assign w_golpe  = w_choque && (r_inv == 2'd0);
  assign w_perder = w_golpe && (r_vidas <= 2'd1);

  // Invulnerability counts evaluation cycles so the next two arrivals are
  // forgiven, regardless of how tk and E interleave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vidas <= 2'd3;
      r_inv   <= 2'd0;
    end else if (w_salida) begin
      r_vidas <= 2'd3;
      r_inv   <= 2'd0;
    end else if (w_golpe) begin
      r_vidas <= (r_vidas == 2'd0) ? 2'd0 : r_vidas - 2'd1;
      r_inv   <= 2'd2;
    end else if (w_eval && (r_inv != 2'd0)) begin
      r_inv   <= r_inv - 2'd1;
    end
  end

  assign bus.vidas = r_vidas;
`else
  assign w_perder  = w_choque;
  assign bus.vidas = 2'd0;
`endif

  // Hero FSM: next state
  always_comb begin
    w_est_nxt = r_est;
    w_cnt_nxt = r_cnt;
    if (w_salida) begin
      w_est_nxt = S_RUN;
      w_cnt_nxt = 2'd0;
    end else if (w_jugando) begin
      unique case (r_est)
        S_RUN: begin
          if (w_jreq) begin
            w_est_nxt = S_JUMP;
            w_cnt_nxt = JT;
          end else if (w_duck) begin
            w_est_nxt = S_DUCK;
          end
        end
        S_JUMP: begin
          if (w_tk) begin
            if (r_cnt <= 2'd1) begin
              w_est_nxt = S_RUN;
              w_cnt_nxt = 2'd0;
            end else begin
              w_cnt_nxt = r_cnt - 2'd1;
            end
          end
        end
        S_DUCK: begin
          if (w_jreq) begin
            w_est_nxt = S_JUMP;
            w_cnt_nxt = JT;
          end else if (!w_duck) begin
            w_est_nxt = S_RUN;
          end
        end
        default: begin
          w_est_nxt = S_RUN;
          w_cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  // Hero FSM: state register and glyph (glyph lags state by one clk)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_est <= S_RUN;
      r_cnt <= 2'd0;
      r_seg <= SEG_RUN;
    end else begin
      r_est <= w_est_nxt;
      r_cnt <= w_cnt_nxt;
      unique case (r_est)
        S_JUMP:  r_seg <= SEG_JUMP;
        S_DUCK:  r_seg <= SEG_DUCK;
        default: r_seg <= SEG_RUN;
      endcase
    end
  end

  // Synchronizers, type pipe, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tk_s <= '0;
      r_sj_s <= '0;
      r_sd_s <= '0;
      r_tk_d <= 1'b0;
      r_tipo <= '0;
      r_wl   <= 2'b00;
      r_bono <= 1'b0;
    end else begin
      r_tk_s <= {r_tk_s[1:0], bus.clk_obstaculos};
      r_sj_s <= {r_sj_s[1:0], bus.boton_salto};
      r_sd_s <= {r_sd_s[0],   bus.boton_agacharse};
      r_tk_d <= w_tk;
      if (w_salida) begin
        r_tipo <= '0;
        r_wl   <= 2'b00;
        r_bono <= 1'b0;
      end else begin
        if (w_tk)
          r_tipo <= {r_tipo[1], r_tipo[0], bus.tipo_obs};
        if (!w_jugando)      r_bono <= 1'b0;
        else if (w_bono_hit) r_bono <= 1'b1;
        else if (w_tk)       r_bono <= 1'b0;
        // A loss at cycle E beats a simultaneous win.
        if (w_jugando) begin
          if (w_perder)
            r_wl <= 2'b01;
          else if ((bus.presente == GAME) && (bus.mundo == 2'd3))
            r_wl <= 2'b10;
        end
      end
    end
  end

  assign bus.W_or_L        = r_wl;
  assign bus.bono_tomado   = r_bono && w_jugando;
  assign bus.display_heroe = r_seg;

endmodule

// File: doc/evaluador_colisiones.md
Name: evaluador_colisiones

Overview:
- Consumer end of the obstacle stream produced by the obstacle generator.
- Tracks the hero (run / jump / duck) against the 3-cell obstacle lane `display_obs` and the per-obstacle type `tipo_obs`.
- Returns `W_or_L` and `bono_tomado` to the generator and to the top-level game state machine.
- Runs entirely on the system clock; the `clk_obstaculos` tick is sampled as data.

Parameters:
- GAME, 3'd3, top FSM "game running" state code.
- WL, 3'd4, top FSM "win/lose screen" state code.
- JUMP_TICKS, 2, obstacle ticks the hero stays airborne.
- TIPO_BONO, 5'd16, `tipo_obs` value marking a bonus cell.
- SEG_RUN, 7'b0001000, hero glyph while running.
- SEG_JUMP, 7'b0000001, hero glyph while airborne.
- SEG_DUCK, 7'b1000000, hero glyph while ducking.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- clk_obstaculos  in  1  obstacle tick from the generator (asynchronous-looking level).
- presente  in  3  top FSM state.
- mundo  in  2  current world; 3 = all worlds cleared.
- tipo_obs  in  5  type of obstacle just written into cell [20:14].
- display_obs  in  21  lane; [6:0] is the hero cell.
- boton_salto  in  1  jump button, raw.
- boton_agacharse  in  1  duck button, raw.
- W_or_L  out  2  00 playing, 10 win, 01 lose.
- bono_tomado  out  1  bonus collected.
- display_heroe  out  7  hero glyph.
- vidas  out  2  remaining lives (see Optional Feature).

Behaviour:
- Reset (async, rst=1) and reset values:
  - W_or_L=00, bono_tomado=0, display_heroe=SEG_RUN, vidas=0.
  - Hero FSM=RUN, type pipe cleared to 0, synchronizers cleared.
- Synchronization:
  - `clk_obstaculos`, `boton_salto` and `boton_agacharse` each pass through 2 flops.
  - Tick edge `tk`: 1-cycle pulse on the synchronized rising edge, i.e. 3 clk after the raw edge.
  - Jump request: synchronized rising edge of `boton_salto`.
- Type pipe (3 × 5 bit), on `tk` only:
  - t0<=tipo_obs, t1<=t0, t2<=t1.
  - t2 is therefore aligned with `display_obs[6:0]`.
- Hero FSM:
  - RUN -> JUMP on a jump request.
  - RUN -> DUCK when `boton_agacharse`=1.
  - Both at once: JUMP wins.
  - JUMP: counter loaded with JUMP_TICKS, decremented on `tk`; at 0 -> RUN. Jump requests during JUMP are ignored.
  - DUCK -> RUN when `boton_agacharse`=0; a jump request in DUCK -> JUMP.
  - `display_heroe` follows the state registered; the glyph changes 1 clk after the state change.
- Evaluation, 1 clk after `tk` (cycle E), only when presente==GAME and W_or_L==00:
  - Cell occupied when `display_obs[6:0]`!=0.
  - Occupied and t2==TIPO_BONO: bono_tomado<=1, held until the next `tk`, then 0. Collected in any hero state.
  - Occupied, t2 odd (ground obstacle), hero not JUMP: collision.
  - Occupied, t2 even and !=TIPO_BONO (aerial obstacle), hero not DUCK: collision.
  - Without VIDAS_EN, a collision sets W_or_L<=01.
- Win:
  - presente==GAME and mundo==3 and W_or_L==00 -> W_or_L<=10 next clk.
  - A collision at cycle E in the same clk has priority: result is 01.
- Hold while W_or_L!=00:
  - W_or_L is sticky.
  - Hero FSM frozen, no further evaluation, bono_tomado=0.
- Game exit: presente not GAME and not WL (synchronous clear, every clk):
  - W_or_L=00, bono_tomado=0, FSM=RUN, pipe cleared.
  - vidas reloaded (feature on).
- Reset asserted mid-jump or with W_or_L set: immediate return to reset values.

Optional Feature:
- Macro VIDAS_EN.
- Defined:
  - Lives counter loaded to 3 on reset or game exit.
  - A collision decrements vidas and starts 2-tick invulnerability, during which collisions are ignored.
  - A collision with vidas==1 sets vidas=0 and W_or_L=01.
  - The `vidas` port carries the count.
- Undefined: the first collision loses; `vidas` is tied to 0.

Test Plan:
- rst pulse mid-game -> next clk: W_or_L=00, display_heroe=7'b0001000, bono_tomado=0.
- presente=3, tipo_obs=5'd3 with top cell non-zero; no button; after 2 further ticks hero cell=7'h3F -> W_or_L=01 at cycle E; holds while presente=4; clears to 00 when presente=0.
- Same ground obstacle, boton_salto pulsed 1 tick before arrival (JUMP_TICKS=2) -> W_or_L stays 00; display_heroe=7'b0000001 for 2 ticks, then 7'b0001000.
- tipo_obs=5'd4 (aerial), boton_agacharse held through arrival -> W_or_L=00, display_heroe=7'b1000000; same stimulus with button released -> W_or_L=01.
- tipo_obs=5'd16 reaches hero cell -> bono_tomado=1 from cycle E until the next tk, then 0; W_or_L=00.
- mundo=3 with presente=3 -> W_or_L=10 next clk. With VIDAS_EN: three spaced ground collisions -> vidas 3→2→1→0, W_or_L=01 only on the third; a second collision within 2 ticks of the first is ignored.
